// File: rtl/div_sequencer.sv
// div_sequencer: multicycle RV32M DIV/DIVU/REM/REMU sequencer.
// Restoring radix-2 divider that holds the pipeline with stallReq while busy.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow skip the
// 32-step loop and go straight from IDLE to DONE.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [4:0]  rdAddrIn,
  output logic        stallReq,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rdAddrOut,
  output logic        regWrite
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;      // partial remainder (upper half of the shift pair)
  logic [31:0] quo;      // dividend shifting out, quotient shifting in
  logic [31:0] dvs;      // divisor magnitude
  logic        is_rem;
  logic        neg_q;
  logic        neg_r;

  // Operand conditioning for the start cycle: funct3[0]=0 selects signed ops.
  logic        signed_op, a_neg, b_neg, div_zero, ovf;
  logic [31:0] a_abs, b_abs, fast_res;

  assign signed_op = ~funct3[0];
  assign a_neg     = signed_op & srcA[31];
  assign b_neg     = signed_op & srcB[31];
  assign a_abs     = a_neg ? (~srcA + 32'd1) : srcA;
  assign b_abs     = b_neg ? (~srcB + 32'd1) : srcB;
  assign div_zero  = (srcB == 32'd0);
  assign ovf       = signed_op & (srcA == 32'h8000_0000) & (srcB == 32'hFFFF_FFFF);
  assign fast_res  = div_zero ? (funct3[1] ? srcA : 32'hFFFF_FFFF)
                              : (funct3[1] ? 32'd0 : 32'h8000_0000);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [32:0] rem_sh, diff;
  logic        take;

  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign take   = (rem_sh >= {1'b0, dvs});

  // Sign fix-up applied in SIGN.
  logic [31:0] q_fin, r_fin;

  assign q_fin = neg_q ? (~quo + 32'd1) : quo;
  assign r_fin = neg_r ? (~rem + 32'd1) : rem;

  // funct3[2] is always 1 for these ops; diff[32] is zero whenever take is set.
  logic unused_ok;
  assign unused_ok = ^{funct3[2], diff[32]};

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result    <= '0;
      rdAddrOut <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          is_rem    <= funct3[1];
          rdAddrOut <= rdAddrIn;
          // Zero divisor must return all-ones quotient, so never negate it.
          neg_q     <= (a_neg ^ b_neg) & ~div_zero;
          neg_r     <= a_neg;
          dvs       <= b_abs;
          quo       <= a_abs;
          rem       <= '0;
          cnt       <= '0;
`ifdef DIV_FASTPATH_EN
          if (div_zero | ovf) begin
            result <= fast_res;
            state  <= DONE;
          end else begin
            state  <= CALC;
          end
`else
          state     <= CALC;
`endif
        end
        CALC: begin
          rem <= take ? diff[31:0] : rem_sh[31:0];
          quo <= {quo[30:0], take};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= SIGN;
        end
        SIGN: begin
          result <= is_rem ? r_fin : q_fin;
          state  <= DONE;
        end
        default: state <= IDLE;   // DONE always returns to IDLE
      endcase
    end
  end

  // Handshake outputs; flush kills them in the same cycle.
  assign busy     = (state != IDLE);
  assign done     = (state == DONE) & ~flush & ~rst;
  assign regWrite = done & (rdAddrOut != 5'd0);
  assign stallReq = ~rst & ~flush &
                    (((state == IDLE) & start) | (state == CALC) | (state == SIGN));

`ifndef DIV_FASTPATH_EN
  // Fast-path conditions only feed the result mux when the macro is set.
  logic unused_fast;
  assign unused_fast = ^{ovf, fast_res};
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed vectors push expected
// result/rd/done-cycle; a negedge monitor pops and compares on every done.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic [4:0]  rdAddrIn;
  logic        stallReq, busy, done, regWrite;
  logic [31:0] result;
  logic [4:0]  rdAddrOut;

  div_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .rdAddrIn(rdAddrIn), .stallReq(stallReq),
    .busy(busy), .done(done), .result(result), .rdAddrOut(rdAddrOut),
    .regWrite(regWrite)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass = 0;
  int   n_tot  = 0;

`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result",    result,    e.res);
        chk("rdAddrOut", {27'd0, rdAddrOut}, {27'd0, e.rd});
        chk("regWrite",  {31'd0, regWrite}, {31'd0, (e.rd != 5'd0)});
        chk("latency",   cyc,       e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one start for one cycle, then scramble operands to prove they are ignored.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit fastcase,
                        input bit push);
    exp_t x;
    funct3 = f; srcA = a; srcB = b; rdAddrIn = rd; start = 1'b1;
    if (push) begin
      x.res = exp; x.rd = rd; x.due = cyc + ((fastcase && FAST) ? 1 : 34);
      sb.push_back(x);
    end
    tick();
    start    = 1'b0;
    srcA     = $urandom;
    srcB     = $urandom;
    funct3   = 3'(4 + $urandom_range(0, 3));
    rdAddrIn = 5'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 80);
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input bit fastcase);
    launch(f, a, b, rd, exp, fastcase, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; funct3 = F_DIV;
    srcA = '0; srcB = '0; rdAddrIn = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_stall",    {31'd0, stallReq}, 32'd0);
    chk("rst_result",   result,            32'd0);
    chk("rst_rd",       {27'd0, rdAddrOut}, 32'd0);
    rst = 1'b0;
    tick();

    // DIVU 100/7: stallReq high in cycles 0..33, low in the done cycle 34.
    funct3 = F_DIVU; srcA = 32'd100; srcB = 32'd7; rdAddrIn = 5'd5; start = 1'b1;
    sb.push_back('{32'd14, 5'd5, cyc + 34});
    for (int i = 0; i <= 34; i++) begin
      @(negedge clk);
      chk("stallReq_divu", {31'd0, stallReq}, {31'd0, (i <= 33)});
      tick();
      start = 1'b0; srcA = $urandom; srcB = $urandom;
    end

    run(F_REM,  32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 1'b0);
    run(F_DIV,  32'hFFFF_FFF9, 32'd2,          5'd7,  32'hFFFF_FFFD, 1'b0);
    run(F_DIVU, 32'd5,         32'd0,          5'd8,  32'hFFFF_FFFF, 1'b1);
    run(F_REMU, 32'd5,         32'd0,          5'd9,  32'd5,         1'b1);
    run(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  5'd10, 32'h8000_0000, 1'b1);
    run(F_REM,  32'h8000_0000, 32'hFFFF_FFFF,  5'd11, 32'd0,         1'b1);
    run(F_DIV,  32'd7,         32'hFFFF_FFFE,  5'd12, 32'hFFFF_FFFD, 1'b0);
    run(F_REM,  32'd7,         32'hFFFF_FFFE,  5'd13, 32'd1,         1'b0);
    run(F_DIV,  32'hFFFF_FFEC, 32'd0,          5'd14, 32'hFFFF_FFFF, 1'b1);
    run(F_REM,  32'hFFFF_FFEC, 32'd0,          5'd15, 32'hFFFF_FFEC, 1'b1);
    run(F_DIVU, 32'hFFFF_FFFF, 32'd1,          5'd16, 32'hFFFF_FFFF, 1'b0);

    // Flush at cycle 10 of a DIV; restart at cycle 11 must finish at cycle 45.
    launch(F_DIV, 32'hFFFF_FFEC, 32'd3, 5'd17, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stallReq}, 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    run(F_DIV, 32'hFFFF_FF9C, 32'd7, 5'd18, 32'hFFFF_FFF2, 1'b0);

    // Reset at cycle 20 of a DIVU, then an rd=0 divide right after release.
    launch(F_DIVU, 32'd1000, 32'd10, 5'd19, 32'd0, 1'b0, 1'b0);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_busy",   {31'd0, busy},     32'd0);
    chk("midrst_stall",  {31'd0, stallReq}, 32'd0);
    chk("midrst_result", result,            32'd0);
    chk("midrst_rd",     {27'd0, rdAddrOut}, 32'd0);
    rst = 1'b0;
    run(F_DIVU, 32'd1000, 32'd10, 5'd0, 32'd100, 1'b0);

    // Back-to-back, then result/rd must hold while idle.
    run(F_REMU, 32'hFFFF_FFFF, 32'h10, 5'd20, 32'hF, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("hold_result", result, 32'hF);
    chk("hold_rd",     {27'd0, rdAddrOut}, 32'd20);
    chk("idle_done",   {31'd0, done}, 32'd0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on posedge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: flush  in  1  kill in-flight divide (mispredict/redirect).
REQ-004 SHALL have ports: start  in  1  execute stage holds a DIV/DIVU/REM/REMU.
REQ-005 SHALL have ports: funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports: srcA  in  32  dividend (forwarded rs1).
REQ-007 SHALL have ports: srcB  in  32  divisor (forwarded rs2).
REQ-008 SHALL have ports: rdAddrIn  in  5  destination register.
REQ-009 SHALL have ports: stallReq  out  1  freeze fetch/decode/execute registers.
REQ-010 SHALL have ports: busy  out  1  state not IDLE.
REQ-011 SHALL have ports: done  out  1  one-cycle result-valid pulse.
REQ-012 SHALL have ports: result  out  32  quotient or remainder.
REQ-013 SHALL have ports: rdAddrOut  out  5  latched rdAddrIn.
REQ-014 SHALL have ports: regWrite  out  1  equals done when rdAddrOut is nonzero, else 0.

Function
REQ-015 SHALL implement states IDLE, CALC, SIGN, DONE.
REQ-016 SHALL, in IDLE with start=1 and flush=0, latch funct3, rdAddrIn, |srcA| and |srcB| (signed ops) or raw values (unsigned ops), and the result sign, then enter CALC with counter=0.
REQ-017 SHALL perform one restoring radix-2 step per CALC cycle on a 33-bit partial remainder; CALC lasts exactly 32 cycles (counter 0..31); counter==31 moves to SIGN.
REQ-018 SHALL in SIGN negate the quotient when dividend sign differs from divisor sign (DIV), negate the remainder when the dividend is negative (REM), then enter DONE.
REQ-019 SHALL in DONE drive done=1 and a valid result, then return to IDLE unconditionally; start sampled in DONE is ignored.
REQ-020 SHALL give latency: start cycle = 0, CALC cycles 1–32, SIGN cycle 33, done in cycle 34.
REQ-021 SHALL drive stallReq = (IDLE & start & !flush) | CALC | SIGN; stallReq=0 in DONE so the instruction advances with the result that cycle.
REQ-022 SHALL ignore srcA/srcB/funct3/rdAddrIn changes after the start cycle.
REQ-023 SHALL on divisor=0 return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = dividend (REM and REMU).
REQ-024 SHALL on DIV 0x80000000 / 0xFFFFFFFF return 0x80000000, and on REM with the same operands return 0.
REQ-025 SHALL hold result and rdAddrOut stable from DONE until the next start is accepted.
REQ-026 SHALL on flush in any state go to IDLE next cycle, clear the counter, suppress done and regWrite, and drop stallReq combinationally; flush has priority over start.
REQ-027 SHALL accept a new start in the cycle after DONE (back-to-back divides).

Reset
REQ-028 SHALL on rst go to IDLE with stallReq=0, busy=0, done=0, regWrite=0, result=0, rdAddrOut=0, counter=0; rst has priority over flush and start, including mid-CALC.

Configuration
REQ-029 SHALL support macro DIV_FASTPATH_EN: when defined, a start whose divisor is 0, or whose operation is signed overflow (DIV/REM, 0x80000000 by 0xFFFFFFFF), goes IDLE->DONE directly with the REQ-023/024 result, giving done in cycle 1 and stallReq high only in cycle 0.
REQ-030 SHALL, with DIV_FASTPATH_EN undefined, run these cases through the full 34-cycle path with identical results.

Verification
REQ-031 SHALL cover: DIVU 100/7 started at cycle 0 -> done=1 at cycle 34, result=14, stallReq high in cycles 0–33 only.
REQ-032 SHALL cover: REM 0xFFFFFFF9 (-7) by 2 -> result 0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-033 SHALL cover: DIVU 5/0 -> result 0xFFFFFFFF; REMU 5/0 -> 5; done at cycle 1 with DIV_FASTPATH_EN, at cycle 34 without.
REQ-034 SHALL cover: DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-035 SHALL cover: flush at cycle 10 of a DIV -> busy=0 at cycle 11, no done/regWrite pulse; a new start at cycle 11 completes normally at cycle 45.
REQ-036 SHALL cover: rst at cycle 20, then a start immediately after reset is released -> correct result; rdAddrOut=0 -> done pulses with regWrite=0.
